// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared lane state type and select qualification for the 1-to-N stream demux
package stream_demux_pkg;
  typedef enum logic {EMPTY, FULL} lane_state_e;
  function automatic logic sel_ok(input int sel, input int n, input logic [63:0] en);
    return (sel < n) && en[sel[5:0]];
  endfunction
endpackage

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one-entry output register slice with EMPTY/FULL handshake state
module demux_lane_reg
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);
  lane_state_e state_q, state_d;
  always_comb begin
    state_d = load ? FULL : (out_ready ? EMPTY : state_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) out_data <= load_data;
    end
  end
  assign out_valid = (state_q == FULL);
endmodule

// File: rtl/stream_demux1ton.sv
// stream_demux1ton: registered 1-to-N valid/ready demux; bad selects are consumed, dropped and counted
module stream_demux1ton
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT),
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OUT-1:0]       lane_en,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   drop_pulse
);
  logic sel_valid, blocked, drop;
  assign sel_valid = sel_ok(32'(in_sel), N_OUT, 64'(lane_en));
  // only the selected lane's occupancy can stall the producer
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < N_OUT; i++)
      blocked = (in_sel == SEL_W'(i)) ? (out_valid[i] & ~out_ready[i]) : blocked;
  end
  assign in_ready = ~(sel_valid & blocked);
  assign drop     = in_valid & ~sel_valid;
  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (in_valid & in_ready & sel_valid & (in_sel == SEL_W'(g))),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g*WIDTH +: WIDTH]),
      .out_valid (out_valid[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      drop_cnt   <= (drop && drop_cnt != '1) ? drop_cnt + CNT_W'(1) : drop_cnt;
    end
  end
endmodule

// File: tb/tb_stream_demux1ton.sv
// tb_stream_demux1ton: directed + random checks of the demux against a per-lane queue model
module tb_stream_demux1ton;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  lane_en = 4'hF;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'hF;
  logic [7:0]  drop_cnt;
  logic        drop_pulse;
  logic [7:0]  d3_in_data = '0;
  logic [1:0]  d3_in_sel = '0;
  logic        d3_in_valid = 1'b0;
  logic        d3_in_ready;
  logic [2:0]  d3_lane_en = 3'b111;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [2:0]  d3_out_ready = 3'b111;
  logic [7:0]  d3_drop_cnt;
  logic        d3_drop_pulse;
  int vecs = 0;
  int errs = 0;
  logic [7:0] q [4][$];
  int  drops = 0;
  bit  exp_pulse = 0;
  bit  last_acc;

  always #5 clk = ~clk;

  stream_demux1ton #(.WIDTH(8), .N_OUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .lane_en(lane_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse));

  stream_demux1ton #(.WIDTH(8), .N_OUT(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .lane_en(d3_lane_en), .out_data(d3_out_data), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .drop_cnt(d3_drop_cnt), .drop_pulse(d3_drop_pulse));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    drops = 0;
    exp_pulse = 0;
  endtask

  // one clock of the model: accepted words join their lane queue, consumed heads leave
  task automatic step(output bit acc);
    bit ok, rdy;
    #1;
    ok  = lane_en[in_sel];
    rdy = !ok || q[in_sel].size() == 0 || out_ready[in_sel];
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    acc = in_valid && rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (out_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (acc && ok) q[in_sel].push_back(in_data);
    if (acc && !ok) drops++;
    exp_pulse = acc && !ok;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]}, {63'd0, q[i].size() > 0});
      if (q[i].size() > 0) chk($sformatf("out_data[%0d]", i), 64'(out_data[i*8 +: 8]), 64'(q[i][0]));
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(drops > 255 ? 255 : drops));
    chk("drop_pulse", {63'd0, drop_pulse}, {63'd0, exp_pulse});
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s);
    in_data = d; in_sel = s; in_valid = 1'b1;
    step(last_acc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // steering, all lanes ready
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 2'(i));
      chk("steer_acc", {63'd0, last_acc}, 64'd1);
      chk("steer_data", 64'(out_data[i*8 +: 8]), 64'(8'hA0 + 8'(i)));
    end
    in_valid = 1'b0;
    step(last_acc);
    // backpressure on lane 2
    out_ready = 4'b1011;
    send(8'hB0, 2'd2);
    chk("bp_hold_valid", {63'd0, out_valid[2]}, 64'd1);
    send(8'hB2, 2'd1);
    chk("bp_other_lane", {63'd0, last_acc}, 64'd1);
    send(8'hB1, 2'd2);
    chk("bp_stall", {63'd0, last_acc}, 64'd0);
    chk("bp_held_data", 64'(out_data[23:16]), 64'hB0);
    out_ready = 4'hF;
    send(8'hB1, 2'd2);
    chk("bp_release_acc", {63'd0, last_acc}, 64'd1);
    chk("bp_no_bubble", 64'(out_data[23:16]), 64'hB1);
    // pass-through refill on lane 0
    out_ready = 4'b1110;
    send(8'hC0, 2'd0);
    out_ready = 4'hF;
    send(8'hC1, 2'd0);
    chk("pt_valid", {63'd0, out_valid[0]}, 64'd1);
    chk("pt_data", 64'(out_data[7:0]), 64'hC1);
    // disabled lane drops on the 4-lane instance
    lane_en = 4'b1101;
    send(8'hD0, 2'd1);
    chk("en_drop_cnt", 64'(drop_cnt), 64'd1);
    lane_en = 4'hF;
    // asynchronous reset mid-stream
    out_ready = 4'h0;
    send(8'hE0, 2'd3);
    in_data = 8'hE1; in_sel = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_cnt", 64'(drop_cnt), 64'h0);
    @(posedge clk);
    #1;
    chk("in_rst_no_accept", 64'(out_valid), 64'h0);
    model_reset();
    in_valid = 1'b0;
    out_ready = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // random traffic
    last_acc = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = 8'($urandom);
        in_sel   = 2'($urandom);
      end
      out_ready = 4'($urandom);
      for (int i = 0; i < 4; i++) lane_en[i] = ($urandom_range(0, 7) != 0);
      step(last_acc);
    end
    in_valid = 1'b0;
    // drops and saturation on the 3-lane instance
    d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_lane_en = 3'b111;
    #1;
    chk("d3_rdy_badsel", {63'd0, d3_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("d3_pulse1", {63'd0, d3_drop_pulse}, 64'd1);
    chk("d3_cnt1", 64'(d3_drop_cnt), 64'd1);
    d3_in_sel = 2'd1; d3_lane_en = 3'b101;
    #1;
    chk("d3_rdy_dis", {63'd0, d3_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("d3_pulse2", {63'd0, d3_drop_pulse}, 64'd1);
    chk("d3_cnt2", 64'(d3_drop_cnt), 64'd2);
    chk("d3_no_load", 64'(d3_out_valid), 64'd0);
    d3_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("d3_pulse_off", {63'd0, d3_drop_pulse}, 64'd0);
    chk("d3_cnt_hold", 64'(d3_drop_cnt), 64'd2);
    d3_in_valid = 1'b1; d3_in_sel = 2'd3;
    repeat (300) @(posedge clk);
    #1;
    d3_in_valid = 1'b0;
    chk("d3_saturate", 64'(d3_drop_cnt), 64'd255);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
